// File: rtl/nfcm_seq_pkg.sv
// Shared types for the NFC command sequencer: opcodes, status codes, FSM states
// and the queued request record.
package nfcm_seq_pkg;

  typedef enum logic [2:0] {
    OP_READ   = 3'b001,
    OP_PROG   = 3'b100,
    OP_ERASE  = 3'b011,
    OP_RESET  = 3'b110,
    OP_READID = 3'b101
  } op_e;

  typedef enum logic [2:0] {
    ST_OK      = 3'd0,
    ST_PERR    = 3'd1,
    ST_EERR    = 3'd2,
    ST_RERR    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_BADOP   = 3'd5
  } status_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] addr;
  } req_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op inside {OP_READ, OP_PROG, OP_ERASE, OP_RESET, OP_READID};
  endfunction

endpackage

// File: rtl/nfcm_cmd_sequencer_if.sv
// Request, controller-handshake and response signals of the command sequencer.
// The sequencer takes the slave view; the host/controller side takes the master view.
interface nfcm_cmd_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_addr;
  logic [2:0]  nfc_cmd;
  logic        nfc_strt;
  logic [15:0] RWA;
  logic        nfc_done;
  logic        PErr;
  logic        EErr;
  logic        RErr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_op;
  logic [15:0] rsp_addr;
  logic [2:0]  rsp_status;
  logic        busy;

  modport slave (
    input  req_valid, req_op, req_addr, nfc_done, PErr, EErr, RErr, rsp_ready,
    output req_ready, nfc_cmd, nfc_strt, RWA, rsp_valid, rsp_op, rsp_addr, rsp_status, busy
  );

  modport master (
    output req_valid, req_op, req_addr, nfc_done, PErr, EErr, RErr, rsp_ready,
    input  req_ready, nfc_cmd, nfc_strt, RWA, rsp_valid, rsp_op, rsp_addr, rsp_status, busy
  );
endinterface

// File: rtl/nfcm_seq_fifo.sv
// Synchronous request FIFO; DEPTH must be a power of two so pointers wrap naturally.
module nfcm_seq_fifo
  import nfcm_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  req_t i_data,
  input  logic i_pop,
  output req_t o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  req_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FullCnt);
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/nfcm_cmd_sequencer.sv
// Queues flash operations and issues them one at a time to nfcm_top, returning one status each.
// Define NFCM_SEQ_RETRY_EN to retry failed/timed-out operations up to MAX_RETRY times.
module nfcm_cmd_sequencer
  import nfcm_seq_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMEOUT_CYC = 65536,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  nfcm_cmd_sequencer_if.slave   bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC);
  // Counter is 0 in the first WAIT cycle, so this is the cycle it would reach TIMEOUT_CYC-1.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 2);

  state_e      r_state;
  req_t        r_req;
  logic        r_strt;
  logic [2:0]  r_cmd;
  logic [15:0] r_rwa;
  logic [CntW-1:0] r_cnt;
  logic        r_rsp_valid;
  logic [2:0]  r_rsp_op;
  logic [15:0] r_rsp_addr;
  logic [2:0]  r_rsp_status;

  req_t        w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_retry;
  status_e     w_status;

`ifdef NFCM_SEQ_RETRY_EN
  localparam int unsigned RetryW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
  logic [RetryW-1:0] r_retry;
  assign w_retry = (w_status != ST_OK) && (r_retry < RetryMax);
`else
  logic w_unused_max_retry;
  assign w_unused_max_retry = ^MAX_RETRY;
  assign w_retry = 1'b0;
`endif

  assign w_pop = (r_state == StIdle) && !w_empty && !r_rsp_valid;

  nfcm_seq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.req_valid && bus.req_ready),
    .i_data  ({bus.req_op, bus.req_addr}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_status = ST_TIMEOUT;
    if (bus.nfc_done) begin
      if (bus.PErr)      w_status = ST_PERR;
      else if (bus.EErr) w_status = ST_EERR;
      else if (bus.RErr) w_status = ST_RERR;
      else               w_status = ST_OK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_req        <= '0;
      r_strt       <= 1'b0;
      r_cmd        <= '0;
      r_rwa        <= '0;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_op     <= '0;
      r_rsp_addr   <= '0;
      r_rsp_status <= '0;
`ifdef NFCM_SEQ_RETRY_EN
      r_retry      <= '0;
`endif
    end else begin
      r_strt <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_req <= w_head;
`ifdef NFCM_SEQ_RETRY_EN
            r_retry <= '0;
`endif
            if (op_legal(w_head.op)) begin
              r_cmd   <= w_head.op;
              r_rwa   <= w_head.addr;
              r_strt  <= 1'b1;
              r_state <= StIssue;
            end else begin
              r_rsp_valid  <= 1'b1;
              r_rsp_op     <= w_head.op;
              r_rsp_addr   <= w_head.addr;
              r_rsp_status <= ST_BADOP;
              r_state      <= StResp;
            end
          end
        end
        StIssue: begin
          r_cnt   <= '0;
          r_state <= StWait;
        end
        StWait: begin
          r_cnt <= r_cnt + 1'b1;
          if (bus.nfc_done || (r_cnt == CntLast)) begin
            if (w_retry) begin
`ifdef NFCM_SEQ_RETRY_EN
              r_retry <= r_retry + 1'b1;
`endif
              r_strt  <= 1'b1;
              r_state <= StIssue;
            end else begin
              r_rsp_valid  <= 1'b1;
              r_rsp_op     <= r_req.op;
              r_rsp_addr   <= r_req.addr;
              r_rsp_status <= w_status;
              r_state      <= StResp;
            end
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = !w_full && !rst;
  assign bus.nfc_cmd    = r_cmd;
  assign bus.nfc_strt   = r_strt;
  assign bus.RWA        = r_rwa;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_op     = r_rsp_op;
  assign bus.rsp_addr   = r_rsp_addr;
  assign bus.rsp_status = r_rsp_status;
  assign bus.busy       = (r_state != StIdle) || !w_empty;

endmodule

// File: tb/tb_nfcm_cmd_sequencer.sv
// Directed bench for nfcm_cmd_sequencer with a response scoreboard and a simple nfcm_top model.
// Retry expectations follow NFCM_SEQ_RETRY_EN.
module tb_nfcm_cmd_sequencer;
  import nfcm_seq_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [2:0]  st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  // nfcm_top model controls
  int   nfc_delay = 5;
  logic m_perr    = 1'b0;
  logic m_eerr    = 1'b0;
  logic m_rerr    = 1'b0;
  int   m_fail_n  = 0;
  int   strt_cnt  = 0;
  logic prev_strt = 1'b0;

  nfcm_cmd_sequencer_if bus ();
  nfcm_cmd_sequencer_if bus_t ();

  nfcm_cmd_sequencer #(
    .DEPTH       (8),
    .TIMEOUT_CYC (64),
    .MAX_RETRY   (2)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Short-timeout instance with retries disabled for the timeout scenario.
  nfcm_cmd_sequencer #(
    .DEPTH       (8),
    .TIMEOUT_CYC (16),
    .MAX_RETRY   (0)
  ) u_dut_to (
    .clk (clk),
    .rst (rst),
    .bus (bus_t.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_nfc"}, 32'({bus.nfc_strt, bus.nfc_cmd, bus.RWA}), 0);
    chk({tag, "_rsp"}, 32'({bus.rsp_valid, bus.rsp_op, bus.rsp_addr, bus.rsp_status, bus.busy}), 0);
  endtask

  task automatic push(input logic [2:0] op, input logic [15:0] addr, input logic [2:0] st);
    int   n = 0;
    exp_t e;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_valid = 1'b1;
    while (bus.req_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 32'(bus.req_ready), 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    e = '{op, addr, st};
    sb.push_back(e);
  endtask

  task automatic collect(input string tag);
    int   n = 0;
    exp_t e;
    while (bus.rsp_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 1);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_unexpected_rsp observed=rsp expected=none", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_op"}, 32'(bus.rsp_op), 32'(e.op));
      chk({tag, "_addr"}, 32'(bus.rsp_addr), 32'(e.addr));
      chk({tag, "_status"}, 32'(bus.rsp_status), 32'(e.st));
    end
    if (bus.rsp_valid === 1'b1) begin
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
    end
  endtask

  // nfcm_top model: answers each start pulse with a done after nfc_delay cycles.
  initial begin
    bus.nfc_done = 1'b0;
    bus.PErr     = 1'b0;
    bus.EErr     = 1'b0;
    bus.RErr     = 1'b0;
    forever begin
      if (bus.nfc_strt === 1'b1) begin
        repeat (nfc_delay) @(negedge clk);
        bus.nfc_done = 1'b1;
        if (m_fail_n > 0) begin
          bus.EErr = 1'b1;
          m_fail_n--;
        end else begin
          bus.PErr = m_perr;
          bus.EErr = m_eerr;
          bus.RErr = m_rerr;
        end
        @(negedge clk);
        bus.nfc_done = 1'b0;
        bus.PErr     = 1'b0;
        bus.EErr     = 1'b0;
        bus.RErr     = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  always @(negedge clk) begin
    if (bus.nfc_strt === 1'b1) begin
      strt_cnt++;
      chk("strt_single_cycle", 32'(prev_strt), 0);
    end
    prev_strt = bus.nfc_strt;
  end

  initial begin
    logic [2:0] ops [5];
    int         s0;
    int         n;
    logic       seen;
    ops = '{OP_READ, OP_PROG, OP_ERASE, OP_RESET, OP_READID};

    bus.req_valid   = 1'b0;
    bus.req_op      = '0;
    bus.req_addr    = '0;
    bus.rsp_ready   = 1'b0;
    bus_t.req_valid = 1'b0;
    bus_t.req_op    = '0;
    bus_t.req_addr  = '0;
    bus_t.rsp_ready = 1'b0;
    bus_t.nfc_done  = 1'b0;
    bus_t.PErr      = 1'b0;
    bus_t.EErr      = 1'b0;
    bus_t.RErr      = 1'b0;

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_rst", 32'(bus.req_ready), 1);

    // Erase: minimum latency, command/address, single strt, OK
    nfc_delay = 40;
    push(OP_ERASE, 16'h1234, ST_OK);
    chk("erase_strt_early", 32'(bus.nfc_strt), 0);
    @(negedge clk);
    chk("erase_strt", 32'(bus.nfc_strt), 1);
    chk("erase_cmd", 32'(bus.nfc_cmd), 32'(3'b011));
    chk("erase_rwa", 32'(bus.RWA), 32'(16'h1234));
    chk("erase_busy", 32'(bus.busy), 1);
    @(negedge clk);
    chk("erase_strt_drop", 32'(bus.nfc_strt), 0);
    collect("erase");

    // Timeout on the short-timeout instance, then a normal OP_RESET
    bus_t.req_op    = OP_ERASE;
    bus_t.req_addr  = 16'h00AA;
    bus_t.req_valid = 1'b1;
    @(negedge clk);
    bus_t.req_valid = 1'b0;
    n = 0;
    while (bus_t.nfc_strt !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("to_strt", 32'(bus_t.nfc_strt), 1);
    repeat (15) @(negedge clk);
    chk("to_not_yet", 32'(bus_t.rsp_valid), 0);
    @(negedge clk);
    chk("to_rsp_valid", 32'(bus_t.rsp_valid), 1);
    chk("to_status", 32'(bus_t.rsp_status), 32'(ST_TIMEOUT));
    chk("to_addr", 32'(bus_t.rsp_addr), 32'(16'h00AA));
    bus_t.rsp_ready = 1'b1;
    @(negedge clk);
    bus_t.rsp_ready = 1'b0;
    bus_t.req_op    = OP_RESET;
    bus_t.req_addr  = 16'h0055;
    bus_t.req_valid = 1'b1;
    @(negedge clk);
    bus_t.req_valid = 1'b0;
    n = 0;
    while (bus_t.nfc_strt !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("to_reset_strt", 32'(bus_t.nfc_strt), 1);
    chk("to_reset_cmd", 32'(bus_t.nfc_cmd), 32'(OP_RESET));
    chk("to_reset_rwa", 32'(bus_t.RWA), 32'(16'h0055));
    @(negedge clk);
    bus_t.nfc_done = 1'b1;
    @(negedge clk);
    bus_t.nfc_done = 1'b0;
    n = 0;
    while (bus_t.rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("to_reset_status", 32'({bus_t.rsp_valid, bus_t.rsp_op, bus_t.rsp_status}),
        32'({1'b1, OP_RESET, ST_OK}));
    bus_t.rsp_ready = 1'b1;
    @(negedge clk);
    bus_t.rsp_ready = 1'b0;

    // Error priority
    nfc_delay = 5;
    m_perr = 1'b1; m_rerr = 1'b1;
    push(OP_PROG, 16'h1234, ST_PERR);
    collect("prog_perr");
    m_perr = 1'b0; m_eerr = 1'b1; m_rerr = 1'b1;
    push(OP_ERASE, 16'h2000, ST_EERR);
    collect("erase_eerr");
    m_eerr = 1'b0; m_rerr = 1'b1;
    push(OP_READ, 16'h00F0, ST_RERR);
    collect("read_rerr");
    m_rerr = 1'b0;

    // Two EErr results followed by a clean done
    m_fail_n = 2;
    s0 = strt_cnt;
`ifdef NFCM_SEQ_RETRY_EN
    push(OP_ERASE, 16'hBEEF, ST_OK);
    collect("retry");
    chk("retry_strts", strt_cnt - s0, 3);
`else
    push(OP_ERASE, 16'hBEEF, ST_EERR);
    collect("noretry");
    chk("noretry_strts", strt_cnt - s0, 1);
`endif
    m_fail_n = 0;

    // Backpressure: 9 back-to-back pushes with responses blocked
    nfc_delay = 3;
    for (int i = 0; i < 9; i++) push(ops[i % 5], 16'(16'h0100 + i), ST_OK);
    chk("bp_full_ready", 32'(bus.req_ready), 0);
    chk("bp_busy", 32'(bus.busy), 1);
    chk("bp_rsp_held", 32'(bus.rsp_valid), 1);
    for (int i = 0; i < 9; i++) collect("bp");

    // Illegal opcode: BADOP, no start pulse, command outputs untouched
    s0 = strt_cnt;
    push(3'b111, 16'h0BAD, ST_BADOP);
    collect("badop");
    chk("badop_no_strt", strt_cnt - s0, 0);
    chk("badop_cmd_kept", 32'(bus.nfc_cmd), 32'(OP_RESET));

    // Reset while an OP_READ waits for done
    nfc_delay = 20;
    push(OP_READ, 16'h4321, ST_OK);
    n = 0;
    while (bus.nfc_strt !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rd_strt", 32'(bus.nfc_strt), 1);
    repeat (5) @(negedge clk);
    chk("rd_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", 32'(bus.req_ready), 0);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    sb.delete();
    s0   = strt_cnt;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    chk("midrst_no_rsp", 32'(seen), 0);
    chk("midrst_no_strt", strt_cnt - s0, 0);
    chk("midrst_idle", 32'({bus.busy, bus.req_ready}), 32'(2'b01));
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
